// File: rtl/ov7670_reg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ov7670_reg_sequencer: boot-time OV7670 register table walker for SCCB/I2C. |
// | Optional write readback verification: OV7670_READBACK_VERIFY_EN.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ov7670_reg_sequencer #(
  parameter logic [7:0] SLAVE_ADDR   = 8'h42,
  parameter int         TABLE_LEN    = 64,
  parameter int         GAP_CYCLES   = 16,
  parameter int         DELAY_CYCLES = 50000,
  parameter int         MAX_RETRY    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [23:0] i2c_wdata_o,
  output logic        go_o,
  output logic        wr_o,
  input  logic        end_i,
  input  logic        ack_i,
  input  logic [7:0]  i2c_rdata_i,
  output logic [7:0]  idx_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int c_timer_max = (GAP_CYCLES > DELAY_CYCLES) ? GAP_CYCLES : DELAY_CYCLES;
  localparam int c_timer_w   = $clog2(c_timer_max + 1);
  localparam int c_retry_w   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [7:0]           c_idx_end    = 8'(TABLE_LEN);
  localparam logic [c_timer_w-1:0] c_gap_last   = c_timer_w'(GAP_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_delay_last = c_timer_w'(DELAY_CYCLES - 1);
  localparam logic [c_retry_w-1:0] c_retry_max  = c_retry_w'(MAX_RETRY);
  localparam logic [15:0]          c_end_mark   = 16'hFFFF;
  localparam logic [15:0]          c_delay_mark = 16'hFFF0;
  localparam logic [7:0]           c_wr_addr    = SLAVE_ADDR & 8'hFE;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_ISSUE    = 4'd2,
    S_CHECK    = 4'd3,
    S_GAP      = 4'd4,
    S_DELAY    = 4'd5,
    S_DONE     = 4'd6,
    S_ERROR    = 4'd7,
    S_RD_ISSUE = 4'd8,
    S_RD_CHECK = 4'd9
  } state_e;

  // Register table: {reg_addr, reg_data}; FFF0 waits out the COM7 soft reset.
  function automatic logic [15:0] rom_entry(input logic [7:0] idx);
    logic [15:0] e;
    case (idx)
      8'd0:    e = 16'h1280;
      8'd1:    e = c_delay_mark;
      8'd2:    e = 16'h1101;
      default: e = c_end_mark;
    endcase
    return e;
  endfunction

  function automatic logic [7:0] idx_inc(input logic [7:0] idx);
    return (idx == c_idx_end) ? idx : idx + 8'd1;
  endfunction

  state_e               state_q, state_d;
  logic [7:0]           idx_q, idx_d;
  logic [c_retry_w-1:0] retry_q, retry_d;
  logic [c_timer_w-1:0] timer_q, timer_d;
  logic [23:0]          wdata_q, wdata_d;
  logic                 go_q, go_d;
  logic                 wr_q, wr_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 end_q, end_d;
  logic                 ack_q, ack_d;
  logic                 advance_q, advance_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [15:0]          w_entry;
  logic                 w_end_rise;
  logic                 w_restart;

`ifdef OV7670_READBACK_VERIFY_EN
  localparam logic [7:0] c_com7    = 8'h12;
  localparam logic [7:0] c_rd_addr = SLAVE_ADDR | 8'h01;
  logic [7:0] rdata_q, rdata_d;
`else
  logic unused_rdata;
  assign unused_rdata = ^i2c_rdata_i;
`endif

  assign w_entry    = rom_entry(idx_q);
  assign w_end_rise = end_i & ~end_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    done_d    = done_q;
    error_d   = error_q;
    end_d     = 1'b0;
    ack_d     = ack_q;
    advance_d = advance_q;
    rd_pend_d = rd_pend_q;
    w_restart = 1'b0;
`ifdef OV7670_READBACK_VERIFY_EN
    rdata_d   = rdata_q;
`endif

    case (state_q)
      S_IDLE: w_restart = start_i;

      S_LOAD: begin
        wr_d = 1'b1;
        if (idx_q == c_idx_end || w_entry == c_end_mark) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (w_entry == c_delay_mark) begin
          state_d = S_DELAY;
          timer_d = '0;
        end else begin
          wdata_d = {c_wr_addr, w_entry};
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        end_d = end_i;
        if (w_end_rise) begin
          ack_d   = ack_i;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        timer_d = '0;
        if (!ack_q) begin
          state_d = S_GAP;
`ifdef OV7670_READBACK_VERIFY_EN
          // COM7 self-clears its reset bit, so reading it back cannot match.
          advance_d = (w_entry[15:8] == c_com7);
          rd_pend_d = (w_entry[15:8] != c_com7);
`else
          advance_d = 1'b1;
`endif
        end else if (retry_q < c_retry_max) begin
          retry_d   = retry_q + c_retry_w'(1);
          advance_d = 1'b0;
          state_d   = S_GAP;
        end else begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end
      end

      S_GAP: begin
        if (timer_q == c_gap_last) begin
          timer_d = '0;
`ifdef OV7670_READBACK_VERIFY_EN
          if (rd_pend_q) begin
            rd_pend_d = 1'b0;
            wr_d      = 1'b0;
            wdata_d   = {c_rd_addr, w_entry[15:8], 8'h00};
            state_d   = S_RD_ISSUE;
          end else
`endif
          begin
            if (advance_q) begin
              idx_d   = idx_inc(idx_q);
              retry_d = '0;
            end
            advance_d = 1'b0;
            state_d   = S_LOAD;
          end
        end else begin
          timer_d = timer_q + c_timer_w'(1);
        end
      end

      S_DELAY: begin
        if (timer_q == c_delay_last) begin
          timer_d = '0;
          idx_d   = idx_inc(idx_q);
          state_d = S_LOAD;
        end else begin
          timer_d = timer_q + c_timer_w'(1);
        end
      end

      S_DONE:  w_restart = start_i;
      S_ERROR: w_restart = start_i;

`ifdef OV7670_READBACK_VERIFY_EN
      S_RD_ISSUE: begin
        end_d = end_i;
        if (w_end_rise) begin
          ack_d   = ack_i;
          rdata_d = i2c_rdata_i;
          state_d = S_RD_CHECK;
        end
      end

      S_RD_CHECK: begin
        timer_d = '0;
        // A failed readback rewrites the same entry under the write retry budget.
        if (!ack_q && rdata_q == w_entry[7:0]) begin
          advance_d = 1'b1;
          state_d   = S_GAP;
        end else if (retry_q < c_retry_max) begin
          retry_d   = retry_q + c_retry_w'(1);
          advance_d = 1'b0;
          state_d   = S_GAP;
        end else begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    if (w_restart) begin
      state_d   = S_LOAD;
      idx_d     = '0;
      retry_d   = '0;
      done_d    = 1'b0;
      error_d   = 1'b0;
      advance_d = 1'b0;
      rd_pend_d = 1'b0;
    end

    go_d = (state_d == S_ISSUE) || (state_d == S_RD_ISSUE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      wdata_q   <= '0;
      go_q      <= 1'b0;
      wr_q      <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      end_q     <= 1'b0;
      ack_q     <= 1'b0;
      advance_q <= 1'b0;
      rd_pend_q <= 1'b0;
`ifdef OV7670_READBACK_VERIFY_EN
      rdata_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      wdata_q   <= wdata_d;
      go_q      <= go_d;
      wr_q      <= wr_d;
      done_q    <= done_d;
      error_q   <= error_d;
      end_q     <= end_d;
      ack_q     <= ack_d;
      advance_q <= advance_d;
      rd_pend_q <= rd_pend_d;
`ifdef OV7670_READBACK_VERIFY_EN
      rdata_q   <= rdata_d;
`endif
    end
  end

  assign i2c_wdata_o = wdata_q;
  assign go_o        = go_q;
  assign wr_o        = wr_q;
  assign idx_o       = idx_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_reg_sequencer.sv
`default_nettype none
// Bench for ov7670_reg_sequencer: randomized SCCB slave responder against a
// table-walking reference model.
module tb_ov7670_reg_sequencer;

  localparam int         DLY     = 200;
  localparam int         GAP     = 16;
  localparam int         TLEN    = 64;
  localparam int         MAXR    = 3;
  localparam logic [7:0] SA      = 8'h42;
  localparam int         TIMEOUT = 20000;
`ifdef OV7670_READBACK_VERIFY_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i, start_i, end_i, ack_i;
  logic [7:0]  rdata_i;
  logic [23:0] wdata_o;
  logic        go_o, wr_o, done_o, error_o;
  logic [7:0]  idx_o;

  ov7670_reg_sequencer #(
    .SLAVE_ADDR(SA), .TABLE_LEN(TLEN), .GAP_CYCLES(GAP),
    .DELAY_CYCLES(DLY), .MAX_RETRY(MAXR)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .i2c_wdata_o(wdata_o), .go_o(go_o), .wr_o(wr_o),
    .end_i(end_i), .ack_i(ack_i), .i2c_rdata_i(rdata_i),
    .idx_o(idx_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [15:0] tbl [4] = '{16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF};
  int nack_w [256];
  int bad_r  [256];
  int sl_nack[256];
  int sl_bad [256];
  logic [7:0] regs[256];

  logic [24:0] obs_q[$];
  int          go_cyc_q[$];
  bit          stab_q[$];
  logic [24:0] exp_q[$];
  int          exp_idx;
  bit          exp_done, exp_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 256; a++) begin
      nack_w[a] = 0;
      bad_r[a]  = 0;
    end
  endtask

  // Walk the table as the sequencer should, producing every transfer expected on the bus.
  task automatic build_model();
    int wn[256];
    int rb[256];
    int idx;
    int tries;
    bit fail;
    logic [15:0] e;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    for (int a = 0; a < 256; a++) begin
      wn[a] = nack_w[a];
      rb[a] = bad_r[a];
    end
    idx = 0;
    forever begin
      e = (idx < 4) ? tbl[idx] : 16'hFFFF;
      if (idx == TLEN || e == 16'hFFFF) begin
        exp_done = 1;
        break;
      end
      if (e == 16'hFFF0) begin
        idx++;
        continue;
      end
      tries = 0;
      forever begin
        exp_q.push_back({1'b1, SA & 8'hFE, e});
        fail = (wn[e[15:8]] > 0);
        if (fail) wn[e[15:8]]--;
        if (!fail && RB && e[15:8] != 8'h12) begin
          exp_q.push_back({1'b0, SA | 8'h01, e[15:8], 8'h00});
          fail = (rb[e[15:8]] > 0);
          if (fail) rb[e[15:8]]--;
        end
        if (!fail) break;
        if (tries == MAXR) begin
          exp_err = 1;
          break;
        end
        tries++;
      end
      if (exp_err) break;
      idx++;
    end
    exp_idx = idx;
  endtask

  // SCCB slave stand-in: random END latency and width, NACK/readback faults from sl_* tables.
  initial begin : slave
    logic [24:0] tr;
    logic [7:0]  a;
    int          lat;
    bit          stable, aborted;
    end_i   = 1'b0;
    ack_i   = 1'b0;
    rdata_i = 8'h00;
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (go_o === 1'b1) begin
        tr = {wr_o, wdata_o};
        obs_q.push_back(tr);
        go_cyc_q.push_back(cyc);
        stable  = 1;
        aborted = 0;
        lat = $urandom_range(3, 12);
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (go_o !== 1'b1) begin
            aborted = 1;
            break;
          end
          if ({wr_o, wdata_o} !== tr) stable = 0;
        end
        stab_q.push_back(stable);
        if (!aborted) begin
          a = tr[15:8];
          if (tr[24]) begin
            ack_i = (sl_nack[a] > 0);
            if (sl_nack[a] > 0) sl_nack[a]--;
            else regs[a] = tr[7:0];
            rdata_i = 8'($urandom);
          end else begin
            ack_i = 1'b0;
            if (sl_bad[a] > 0) begin
              rdata_i = 8'h00;
              sl_bad[a]--;
            end else begin
              rdata_i = regs[a];
            end
          end
          end_i = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          end_i = 1'b0;
          ack_i = 1'b0;
        end
      end
    end
  end

  task automatic run_seq(input string tag, input bit inject_start);
    int  n;
    bit  injected;
    build_model();
    for (int a = 0; a < 256; a++) begin
      sl_nack[a] = nack_w[a];
      sl_bad[a]  = bad_r[a];
    end
    obs_q.delete();
    go_cyc_q.delete();
    stab_q.delete();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    injected = 0;
    while (!(done_o === 1'b1 || error_o === 1'b1) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
      if (inject_start && !injected && go_o === 1'b1) begin
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        injected = 1;
      end
    end
    chk({tag, "_timeout"}, (n < TIMEOUT), 1);
    repeat (30) @(negedge clk);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_tr%0d", tag, i), (i < obs_q.size()) ? obs_q[i] : 25'hx, exp_q[i]);
    for (int i = 0; i < stab_q.size(); i++)
      chk($sformatf("%s_stable%0d", tag, i), stab_q[i], 1);
    chk({tag, "_done"},  done_o,  exp_done);
    chk({tag, "_error"}, error_o, exp_err);
    chk({tag, "_idx"},   idx_o,   exp_idx);
    chk({tag, "_go"},    go_o,    0);
  endtask

  initial begin : main
    int n;
    int gap;
    rst_i   = 1'b1;
    start_i = 1'b0;
    clear_faults();
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_go",    go_o,    0);
    chk("rst_wr",    wr_o,    1);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_idx",   idx_o,   0);
    chk("rst_done",  done_o,  0);
    chk("rst_error", error_o, 0);
    repeat (20) @(negedge clk);
    chk("idle_no_go", go_o, 0);

    // All entries ACKed; the delay marker must separate the two writes.
    run_seq("ack_all", 0);
    gap = (go_cyc_q.size() >= 2) ? (go_cyc_q[1] - go_cyc_q[0]) : 0;
    chk("delay_gap", (gap >= DLY), 1);

    clear_faults();
    nack_w[8'h11] = 2;
    run_seq("nack_r11x2", 0);

    clear_faults();
    nack_w[8'h12] = 1000;
    run_seq("nack_r12_all", 0);

    clear_faults();
    run_seq("restart_from_err", 0);

    // Reset while a transfer is outstanding.
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (go_o !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_go_seen", go_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_go",    go_o,    0);
    chk("rst_mid_idx",   idx_o,   0);
    chk("rst_mid_done",  done_o,  0);
    chk("rst_mid_error", error_o, 0);
    rst_i = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_mid_idle", go_o, 0);
    run_seq("after_rst", 0);

    run_seq("rerun_start_in_issue", 1);

`ifdef OV7670_READBACK_VERIFY_EN
    clear_faults();
    bad_r[8'h11] = 1;
    run_seq("rb_bad_once", 0);
`endif

    for (int it = 0; it < 4; it++) begin
      clear_faults();
      nack_w[8'h12] = $urandom_range(0, 4);
      nack_w[8'h11] = $urandom_range(0, 4);
      bad_r[8'h11]  = $urandom_range(0, 2);
      run_seq($sformatf("rand%0d", it), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
